// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle ADD/SUB/logic ops and a WIDTH-cycle shift-add multiplier behind a valid/ready pair.
// Optional ALU_SEQ_FLAGS_EN macro adds registered zero_flag and ovf_flag outputs.
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 out_err,
`ifdef ALU_SEQ_FLAGS_EN
   output logic                 zero_flag,
   output logic                 ovf_flag,
`endif
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_XOR = 3'b001,
      OP_MUL = 3'b010,
      OP_AND = 3'b011,
      OP_SUB = 3'b100,
      OP_OR  = 3'b101
   } op_e;

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e               r_state;
   state_e               w_next;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mplier;
   logic                 r_out_valid;
   logic                 r_out_err;
   logic [2*WIDTH-1:0]   r_result;

   logic                 w_slot_free;
   logic                 w_in_xfer;
   logic                 w_is_mul;
   logic                 w_mul_done;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_alu_res;
   logic                 w_alu_err;

   assign w_slot_free = !r_out_valid || out_ready;
   assign in_ready    = (r_state == S_IDLE) && !rst && w_slot_free;
   assign w_in_xfer   = in_valid && in_ready;
   assign w_is_mul    = (op == OP_MUL);
   // The product sits in r_acc once all iterations ran; it waits there until the output slot frees.
   assign w_mul_done  = (r_state == S_MUL) && (r_cnt == LAST) && w_slot_free;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign out_err   = r_out_err;
   assign busy      = (r_state == S_MUL);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_alu_res = '0;
      w_alu_err = 1'b0;
      case (op)
         OP_ADD:  w_alu_res = {{(WIDTH-1){1'b0}}, w_sum};
         OP_SUB:  w_alu_res = {{(WIDTH-1){1'b0}}, w_diff};
         OP_XOR:  w_alu_res = {{WIDTH{1'b0}}, a ^ b};
         OP_AND:  w_alu_res = {{WIDTH{1'b0}}, a & b};
         OP_OR:   w_alu_res = {{WIDTH{1'b0}}, a | b};
         OP_MUL:  w_alu_res = '0;
         default: w_alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_in_xfer && w_is_mul) w_next = S_MUL;
         S_MUL:   if (w_mul_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_result    <= '0;
      end else begin
         if (w_in_xfer && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_MUL && r_cnt != LAST) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end

         if (w_in_xfer && !w_is_mul) begin
            r_result    <= w_alu_res;
            r_out_err   <= w_alu_err;
            r_out_valid <= 1'b1;
         end else if (w_mul_done) begin
            r_result    <= r_acc;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic w_alu_ovf;
   logic r_zero_flag;
   logic r_ovf_flag;

   // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
   always_comb begin
      w_alu_ovf = 1'b0;
      if (op == OP_ADD)
         w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      else if (op == OP_SUB)
         w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero_flag <= 1'b0;
         r_ovf_flag  <= 1'b0;
      end else if (w_in_xfer && !w_is_mul) begin
         r_zero_flag <= (w_alu_res == '0);
         r_ovf_flag  <= w_alu_ovf;
      end else if (w_mul_done) begin
         r_zero_flag <= (r_acc == '0);
         r_ovf_flag  <= 1'b0;
      end
   end

   assign zero_flag = r_zero_flag;
   assign ovf_flag  = r_ovf_flag;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8): directed corner cases then randomized traffic with random backpressure.
// Compile with +define+ALU_SEQ_FLAGS_EN to also check the flag outputs.
module tb_alu_seq_core;

   localparam int W = 8;

   typedef struct packed {
      logic [2*W-1:0] res;
      logic           err;
      logic           zf;
      logic           ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       op_i = '0;
   logic [W-1:0]     a_i = '0;
   logic [W-1:0]     b_i = '0;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   result;
   logic             out_err;
   logic             busy;
   logic             zero_flag;
   logic             ovf_flag;

   logic             rand_mode = 1'b0;
   logic             rand_ready = 1'b1;
   logic             ready_force = 1'b1;

   int               n_checks = 0;
   int               n_pass = 0;
   exp_t             sb[$];

   assign out_ready = rand_mode ? rand_ready : ready_force;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op_i),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_err   (out_err),
`ifdef ALU_SEQ_FLAGS_EN
      .zero_flag (zero_flag),
      .ovf_flag  (ovf_flag),
`endif
      .busy      (busy)
   );

`ifndef ALU_SEQ_FLAGS_EN
   assign zero_flag = 1'b0;
   assign ovf_flag  = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model from the opcode definitions using plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ux;
      longint uy;
      int     sx;
      int     sy;
      int     s;
      e  = '0;
      ux = longint'(x);
      uy = longint'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      case (o)
         3'd0: begin
            e.res = 16'(ux + uy);
            s = sx + sy;
            e.ovf = (s > 127) || (s < -128);
         end
         3'd1: e.res = 16'(ux ^ uy);
         3'd2: e.res = 16'(ux * uy);
         3'd3: e.res = 16'(ux & uy);
         3'd4: begin
            e.res = 16'(((ux - uy) & 255) + ((ux < uy) ? 256 : 0));
            s = sx - sy;
            e.ovf = (s > 127) || (s < -128);
         end
         3'd5: e.res = 16'(ux | uy);
         default: e.err = 1'b1;
      endcase
      e.zf = (e.res == 0);
      return e;
   endfunction

   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      n = 0;
      op_i = o;
      a_i = x;
      b_i = y;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      sb.push_back(model(o, x, y));
      #1 in_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      #1 rand_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops on every output transfer and checks hold-stability during backpressure.
   logic           prev_stall = 1'b0;
   logic [2*W-1:0] prev_res;
   logic           prev_err;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(prev_res));
            check("hold_err", 32'(out_err), 32'(prev_err));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'(result), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("sb_result", 32'(result), 32'(e.res));
               check("sb_err", 32'(out_err), 32'(e.err));
`ifdef ALU_SEQ_FLAGS_EN
               check("sb_zero_flag", 32'(zero_flag), 32'(e.zf));
               check("sb_ovf_flag", 32'(ovf_flag), 32'(e.ovf));
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
         prev_err   = out_err;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      time    t0;
      int     n;
      logic   saw_out;
      logic [2:0] ro;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // ADD with carry, latency 1
      send(3'b000, 8'hFF, 8'h01);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_result", 32'(result), 32'h0100);
      check("add_err", 32'(out_err), 32'd0);
      @(posedge clk); #1;

      // MUL: busy for the iterations, result WIDTH+1 edges after transfer
      send(3'b010, 8'hFF, 8'hFF);
      for (int i = 0; i < 9; i++) begin
         check("mul_busy", 32'(busy), 32'd1);
         check("mul_in_ready", 32'(in_ready), 32'd0);
         check("mul_no_early_valid", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      check("mul_valid", 32'(out_valid), 32'd1);
      check("mul_result", 32'(result), 32'hFE01);
      check("mul_busy_done", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // XOR under backpressure
      ready_force = 1'b0;
      send(3'b001, 8'hAA, 8'h55);
      check("xor_valid", 32'(out_valid), 32'd1);
      check("xor_result", 32'(result), 32'h00FF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("xor_stall_in_ready", 32'(in_ready), 32'd0);
         check("xor_stall_result", 32'(result), 32'h00FF);
      end
      @(posedge clk);
      #1 ready_force = 1'b1;
      @(posedge clk); #1;
      check("xor_released", 32'(out_valid), 32'd0);

      // illegal opcode
      send(3'b111, 8'h12, 8'h34);
      check("ill_result", 32'(result), 32'h0000);
      check("ill_err", 32'(out_err), 32'd1);
      @(posedge clk); #1;

      // back-to-back throughput: one transfer per cycle
      t0 = $time;
      send(3'b011, 8'hF0, 8'h3C);
      send(3'b101, 8'h0F, 8'h30);
      send(3'b100, 8'h03, 8'h05);
      send(3'b000, 8'h7F, 8'h01);
      check("b2b_cycles", 32'(($time - t0) / 10), 32'd4);
      @(posedge clk); #1;

`ifdef ALU_SEQ_FLAGS_EN
      send(3'b100, 8'h80, 8'h01);
      check("flag_sub_result", 32'(result), 32'h007F);
      check("flag_sub_ovf", 32'(ovf_flag), 32'd1);
      check("flag_sub_zero", 32'(zero_flag), 32'd0);
      send(3'b100, 8'h05, 8'h05);
      check("flag_eq_zero", 32'(zero_flag), 32'd1);
      @(posedge clk); #1;
`endif

      // reset in the middle of a multiply
      send(3'b010, 8'h5A, 8'hC3);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("mulrst_out_valid", 32'(out_valid), 32'd0);
      check("mulrst_busy", 32'(busy), 32'd0);
      sb.delete();
      rst = 1'b0;
      #1 check("mulrst_in_ready", 32'(in_ready), 32'd1);
      saw_out = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (out_valid) saw_out = 1'b1;
      end
      check("mulrst_no_result", 32'(saw_out), 32'd0);
      @(posedge clk); #1;

      // randomized traffic with random output backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ro = 3'($urandom_range(0, 7));
         send(ro, 8'($urandom), 8'($urandom));
         op_i = 3'($urandom);
         a_i  = 8'($urandom);
         b_i  = 8'($urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      rand_mode = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1 check("drain_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
